// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Bundles the load handshake, run controls and status outputs of countdown_timer.
//   master : producer/controller side (drives load/start/pause/stop/auto_reload)
//   slave  : timer side (drives load_ready/count/busy/done)
//   Signals:
//     load_valid, load_ready, load_value[WIDTH] - terminal-count load handshake
//     start, pause, stop, auto_reload           - run controls
//     count[WIDTH], busy, done                  - status
interface countdown_timer_if #(
   parameter int unsigned WIDTH = 4
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             pause;
   logic             stop;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_value, start, pause, stop, auto_reload,
      input  load_ready, count, busy, done
   );

   modport slave (
      input  load_valid, load_value, start, pause, stop, auto_reload,
      output load_ready, count, busy, done
   );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counter. A terminal count is accepted over a valid/ready load
//   handshake, counted down to zero after start, and a one-cycle done pulse is
//   emitted on expiry. With auto_reload the loaded value is reloaded on expiry
//   to produce periodic ticks.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - countdown_timer_if.slave (load handshake, controls, count/busy/done)
module countdown_timer #(
   parameter int unsigned WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   countdown_timer_if.slave  bus
);

   typedef enum logic [1:0] {
      StIdle,
      StLoaded,
      StRun,
      StPause
   } state_e;

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             done_q, done_d;
   logic             load_fire;

   // Ready is decoded straight from state so the producer sees it in the same cycle.
   assign bus.load_ready = (state_q == StIdle) || (state_q == StLoaded);
   assign bus.busy       = (state_q == StRun) || (state_q == StPause);
   assign bus.count      = count_q;
   assign bus.done       = done_q;

   assign load_fire = bus.load_valid && bus.load_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (load_fire) begin
               count_d  = bus.load_value;
               reload_d = bus.load_value;
               state_d  = StLoaded;
            end
         end
         StLoaded: begin
            // A load beats a simultaneous start.
            if (load_fire) begin
               count_d  = bus.load_value;
               reload_d = bus.load_value;
            end else if (bus.start) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (bus.pause) begin
               state_d = StPause;
            end else if (count_q > One) begin
               count_d = count_q - One;
            end else begin
               // Expiry covers count==1 and a zero load; count never underflows.
               done_d  = 1'b1;
               count_d = bus.auto_reload ? reload_q : '0;
               state_d = (bus.auto_reload && (reload_q != '0)) ? StRun : StIdle;
            end
         end
         StPause: begin
            // Resume edge only changes state; the decrement resumes next edge.
            if (!bus.pause) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Stop overrides everything else, including an expiry in the same cycle.
      if (bus.stop && (state_q != StIdle)) begin
         state_d = StIdle;
         count_d = '0;
         done_d  = 1'b0;
      end
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: the decrementing counterpart of the free-running 4-bit up-counter.
- Accepts a terminal count over a valid/ready load handshake and counts it down to zero when started.
- Emits a one-cycle done pulse on expiry, with optional auto-reload for periodic ticks.
- Used as the timeout/period generator beside the up-counter in the counter subsystem.

Parameters:
- WIDTH, 4, width of count, load_value and internal reload register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; asserting rst=0 clears all state immediately.
- load_valid  input  1  load_value is valid this cycle.
- load_ready  output  1  block can accept a load (combinational from state).
- load_value  input  WIDTH  terminal count to load.
- start  input  1  begin counting from the loaded value.
- pause  input  1  hold count while high (RUN only).
- stop  input  1  abort counting; highest priority.
- auto_reload  input  1  on expiry reload and continue, else return to IDLE.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high while in RUN or PAUSE.
- done  output  1  registered one-cycle pulse on expiry.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst).
- Reset (rst=0, asynchronous, any state):
  - state=IDLE, count=0, reload_reg=0, done=0.
  - Outputs settle without a clock edge.
- Load handshake: a load occurs on an edge where load_valid && load_ready.
  - count<=load_value, reload_reg<=load_value, state<=LOADED.
- load_ready=1 in IDLE and LOADED; 0 in RUN and PAUSE. Loads offered while not ready are ignored; the producer holds load_valid.
- States and transitions:
  - IDLE: start ignored. Load -> LOADED.
  - LOADED: start && !load_valid -> RUN. A load while in LOADED replaces count and reload_reg and stays LOADED. Load wins over a simultaneous start.
  - RUN: pause=1 -> PAUSE, count held.
    - Otherwise, if count>1: count<=count-1.
    - If count<=1 (expiry): done<=1, count<=auto_reload ? reload_reg : 0.
    - Next state after expiry is RUN if auto_reload && reload_reg!=0, else IDLE.
  - PAUSE: pause=0 -> RUN; no decrement on the resume edge.
- stop=1 in any non-IDLE state: state<=IDLE, count<=0, done<=0, no pulse. stop overrides load, start, pause and expiry in the same cycle.
- done is high for exactly one cycle per expiry and 0 otherwise.
- Latency:
  - Load N>=1, start: RUN entered on the start edge. Expiry (count 1->0, done=1) occurs on the Nth RUN edge after that, excluding paused cycles.
  - Auto-reload with value N gives a done every N unpaused cycles; the sequence is N..1 then N again.
- Boundary cases:
  - Load 0, then start: expires on the first RUN edge (done=1). The block then goes to IDLE even with auto_reload=1.
  - Load value 2^WIDTH-1 counts the full range.
  - auto_reload sampled only at expiry edges.
  - No wrap below 0; count never underflows.
- Arithmetic: unsigned, WIDTH bits, decrement only when count>1.

Test Plan:
- Reset: rst=0 mid-RUN with count=7 -> count=0, done=0, load_ready=1, busy=0 immediately without clock edge.
- Single shot: load 5, start, auto_reload=0 -> count 5,4,3,2,1,0 on successive edges; done=1 only on edge where count becomes 0; then IDLE, busy=0.
- Auto-reload: load 3, start, auto_reload=1 -> count 3,2,1,3,2,1,... with done pulse every 3 cycles; stop -> count=0, IDLE, no done.
- Pause: load 4, start, pause high 3 cycles after first decrement -> count holds 3 for those cycles; done arrives 3+1 cycles later than unpaused.
- Handshake: load_valid with load_value=9 while RUN -> ignored (load_ready=0). In LOADED, load_valid+start same edge -> count=9, state LOADED, not RUN.
- Zero load: load 0, start, auto_reload=1 -> done=1 on first RUN edge, count=0, returns to IDLE.
